// File: rtl/stepper_drive_pkg.sv
// Shared types and helpers for the stepper coil driver.
// Optional macro STEPPER_HOLD_PWM_EN adds the reduced-current HOLD state.
package stepper_drive_pkg;

    typedef logic [1:0] phase_t;
    typedef logic [3:0] coil_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_DRIVE
`ifdef STEPPER_HOLD_PWM_EN
        , ST_HOLD
`endif
    } chan_state_t;

    localparam int COIL_AP = 0;
    localparam int COIL_AN = 1;
    localparam int COIL_BP = 2;
    localparam int COIL_BN = 3;

    // Full-step sequence: each step flips exactly one bridge.
    function automatic coil_t phase_to_coil(phase_t p);
        coil_t c;
        c = '0;
        unique case (p)
            2'd0: begin
                c[COIL_AP] = 1'b1;
                c[COIL_BP] = 1'b1;
            end
            2'd1: begin
                c[COIL_AN] = 1'b1;
                c[COIL_BP] = 1'b1;
            end
            2'd2: begin
                c[COIL_AN] = 1'b1;
                c[COIL_BN] = 1'b1;
            end
            default: begin
                c[COIL_AP] = 1'b1;
                c[COIL_BN] = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stepper_coil_driver_if.sv
// Phase/enable inputs and coil/hold outputs of the coil driver.
// Optional macro STEPPER_HOLD_PWM_EN (hold_out is only active with it).
interface stepper_coil_driver_if #(
    parameter int N_MOTORS = 30
);
    logic [2*N_MOTORS-1:0] phase_in;
    logic [N_MOTORS-1:0]   enable_in;
    logic [4*N_MOTORS-1:0] coil_out;
    logic [N_MOTORS-1:0]   hold_out;

    modport master (
        output phase_in,
        output enable_in,
        input  coil_out,
        input  hold_out
    );

    modport slave (
        input  phase_in,
        input  enable_in,
        output coil_out,
        output hold_out
    );
endinterface

// File: rtl/stepper_coil_channel.sv
// One motor channel: dead-time FSM, registered coil pattern.
// Optional macro STEPPER_HOLD_PWM_EN adds idle timeout and PWM hold.
module stepper_coil_channel
    import stepper_drive_pkg::*;
#(
    parameter int DEAD_CYCLES  = 8,
    parameter int HOLD_TIMEOUT = 1000000,
    parameter int HOLD_DUTY    = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  phase_t phase_i,
    input  logic   enable_i,
`ifdef STEPPER_HOLD_PWM_EN
    input  logic [3:0] pwm_cnt_i,
`endif
    output coil_t  coil_o,
    output logic   hold_o
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    chan_state_t state_q, state_d;
    phase_t      last_q, last_d;
    logic [7:0]  dead_q, dead_d;
    coil_t       coil_q, coil_d;
    logic        phase_chg;

    assign phase_chg = (phase_i != last_q);

`ifdef STEPPER_HOLD_PWM_EN
    localparam int IW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(HOLD_TIMEOUT - 1);
    localparam logic [4:0] DUTY = 5'(HOLD_DUTY);

    logic [IW-1:0] idle_q, idle_d;
    logic          pwm_on;

    assign pwm_on = ({1'b0, pwm_cnt_i} < DUTY);
    assign hold_o = (state_q == ST_HOLD);
`else
    assign hold_o = 1'b0;
`endif

    assign coil_o = coil_q;

    // Next state, counters and next coil pattern; disable wins over everything.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dead_d  = dead_q;
        coil_d  = '0;
`ifdef STEPPER_HOLD_PWM_EN
        idle_d  = idle_q;
`endif
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    dead_d  = DEAD_LOAD;
                    last_d  = phase_i;
                end
                ST_DEAD: begin
                    if (phase_chg) begin
                        dead_d = DEAD_LOAD;
                        last_d = phase_i;
                    end else if (dead_q == 8'd0) begin
                        state_d = ST_DRIVE;
`ifdef STEPPER_HOLD_PWM_EN
                        idle_d  = '0;
`endif
                    end else begin
                        dead_d = dead_q - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (phase_chg) begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                        last_d  = phase_i;
                    end
`ifdef STEPPER_HOLD_PWM_EN
                    else if (idle_q == IDLE_LAST) begin
                        state_d = ST_HOLD;
                    end else if (idle_q != '1) begin
                        idle_d = idle_q + IW'(1);
                    end
`endif
                end
`ifdef STEPPER_HOLD_PWM_EN
                ST_HOLD: begin
                    if (phase_chg) begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                        last_d  = phase_i;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        unique case (state_d)
            ST_DRIVE: coil_d = phase_to_coil(last_d);
`ifdef STEPPER_HOLD_PWM_EN
            ST_HOLD:  coil_d = pwm_on ? phase_to_coil(last_d) : '0;
`endif
            default:  coil_d = '0;
        endcase
    end

    // Channel state registers; reset forces the bridge off at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            dead_q  <= '0;
            coil_q  <= '0;
`ifdef STEPPER_HOLD_PWM_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            dead_q  <= dead_d;
            coil_q  <= coil_d;
`ifdef STEPPER_HOLD_PWM_EN
            idle_q  <= idle_d;
`endif
        end
    end

endmodule

// File: rtl/stepper_coil_driver.sv
// Per-motor H-bridge gate driver with break-before-make dead time.
// Optional macro STEPPER_HOLD_PWM_EN enables the shared hold PWM counter.
module stepper_coil_driver
    import stepper_drive_pkg::*;
#(
    parameter int N_MOTORS     = 30,
    parameter int DEAD_CYCLES  = 8,
    parameter int HOLD_TIMEOUT = 1000000,
    parameter int HOLD_DUTY    = 4
) (
    input logic system1000,
    input logic system1000_rst,
    stepper_coil_driver_if.slave bus
);

    coil_t                 coil_w [N_MOTORS];
    logic [4*N_MOTORS-1:0] coil_vec;
    logic [N_MOTORS-1:0]   hold_vec;

`ifdef STEPPER_HOLD_PWM_EN
    logic [3:0] pwm_cnt_q;

    // Free-running 16-step PWM phase shared by every channel.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end
`endif

    for (genvar i = 0; i < N_MOTORS; i++) begin : g_chan
        stepper_coil_channel #(
            .DEAD_CYCLES  (DEAD_CYCLES),
            .HOLD_TIMEOUT (HOLD_TIMEOUT),
            .HOLD_DUTY    (HOLD_DUTY)
        ) u_chan (
            .clk_i     (system1000),
            .rst_i     (system1000_rst),
            .phase_i   (bus.phase_in[2*i +: 2]),
            .enable_i  (bus.enable_in[i]),
`ifdef STEPPER_HOLD_PWM_EN
            .pwm_cnt_i (pwm_cnt_q),
`endif
            .coil_o    (coil_w[i]),
            .hold_o    (hold_vec[i])
        );

        assign coil_vec[4*i +: 4] = coil_w[i];
    end

    assign bus.coil_out = coil_vec;
    assign bus.hold_out = hold_vec;

endmodule
